// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and sizing helper shared by the sync and async FIFOs
package fifo_pkg;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: FIFO storage with one synchronous write port and an asynchronous read port
module fifo_sync_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_circular_prog.sv
// fifo_sync_circular_prog: single-clock circular FIFO with level, thresholds, sticky errors and FWFT/registered read
module fifo_sync_circular_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int FWFT          = FIFO_MODE_FWFT,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                         clk,
  input  logic                         nrst_in,
  input  logic                         write_in,
  input  logic [WIDTH-1:0]             data_write_in,
  input  logic                         read_in,
  output logic [WIDTH-1:0]             data_read_out,
  output logic                         valid_out,
  output logic                         full_out,
  output logic                         empty_out,
  output logic                         almost_full_out,
  output logic                         almost_empty_out,
  output logic [fifo_cnt_w(DEPTH)-1:0] level_out,
  output logic                         overflow_out,
  output logic                         underflow_out,
  input  logic                         clear_err_in
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = fifo_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] AF = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AE = CNT_W'(AEMPTY_THRESH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "fifo_sync_circular_prog: DEPTH must be a power of two >= 2");
  end
  if (AFULL_THRESH > DEPTH) begin : g_bad_afull
    $fatal(1, "fifo_sync_circular_prog: AFULL_THRESH exceeds DEPTH");
  end
  if (AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
    $fatal(1, "fifo_sync_circular_prog: AEMPTY_THRESH must be below DEPTH");
  end
  logic [ADDR_W:0]  wr_ptr, rd_ptr;
  logic [WIDTH-1:0] ram_rdata, rdata_q;
  logic             valid_q, wr_acc, rd_acc;
  assign empty_out        = wr_ptr == rd_ptr;
  assign full_out         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign level_out        = wr_ptr - rd_ptr;
  assign almost_full_out  = level_out >= AF;
  assign almost_empty_out = level_out <= AE;
  assign wr_acc           = write_in && !full_out;
  assign rd_acc           = read_in && !empty_out;
  assign data_read_out    = FWFT == FIFO_MODE_FWFT ? ram_rdata : rdata_q;
  assign valid_out        = FWFT == FIFO_MODE_FWFT ? !empty_out : valid_q;
  fifo_sync_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_acc && nrst_in),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_write_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );
  // a new error in the same cycle as clear_err_in keeps the flag set
  always_ff @(posedge clk) begin
    if (!nrst_in) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rdata_q       <= '0;
      valid_q       <= 1'b0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      wr_ptr        <= wr_acc ? wr_ptr + (ADDR_W+1)'(1) : wr_ptr;
      rd_ptr        <= rd_acc ? rd_ptr + (ADDR_W+1)'(1) : rd_ptr;
      rdata_q       <= rd_acc ? ram_rdata : rdata_q;
      valid_q       <= rd_acc;
      overflow_out  <= (write_in && full_out) || (overflow_out && !clear_err_in);
      underflow_out <= (read_in && empty_out) || (underflow_out && !clear_err_in);
    end
  end
endmodule

// File: tb/tb_fifo_sync_circular_prog.sv
// tb_fifo_sync_circular_prog: directed checks of an FWFT and a registered-read instance driven in lockstep
module tb_fifo_sync_circular_prog;
  logic       clk = 0, nrst = 0, wr = 0, rd = 0, clr = 0;
  logic [7:0] wdata = 0;
  logic [7:0] f_data, s_data;
  logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [4:0] f_level, s_level;
  int         total = 0, bad = 0;
  logic [7:0] q[$];
  logic [7:0] head;
  always #5 clk = ~clk;
  fifo_sync_circular_prog #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_fwft (
    .clk(clk), .nrst_in(nrst), .write_in(wr), .data_write_in(wdata), .read_in(rd),
    .data_read_out(f_data), .valid_out(f_valid), .full_out(f_full), .empty_out(f_empty),
    .almost_full_out(f_af), .almost_empty_out(f_ae), .level_out(f_level),
    .overflow_out(f_ovf), .underflow_out(f_udf), .clear_err_in(clr));
  fifo_sync_circular_prog #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_std (
    .clk(clk), .nrst_in(nrst), .write_in(wr), .data_write_in(wdata), .read_in(rd),
    .data_read_out(s_data), .valid_out(s_valid), .full_out(s_full), .empty_out(s_empty),
    .almost_full_out(s_af), .almost_empty_out(s_ae), .level_out(s_level),
    .overflow_out(s_ovf), .underflow_out(s_udf), .clear_err_in(clr));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    nrst = 1;
    chk("rst_empty", f_empty, 1);
    chk("rst_aempty", f_ae, 1);
    chk("rst_level", f_level, 0);
    chk("rst_full", f_full, 0);
    chk("rst_afull", f_af, 0);
    chk("rst_fvalid", f_valid, 0);
    chk("rst_svalid", s_valid, 0);
    chk("rst_sdata", s_data, 0);
    chk("rst_ovf", f_ovf, 0);
    chk("rst_udf", s_udf, 0);
    for (int i = 0; i < 16; i++) begin
      wr = 1;
      wdata = 8'(i);
      tick();
      chk("fill_level", f_level, i + 1);
      chk("fill_afull", f_af, (i + 1) >= 12);
      chk("fill_full", f_full, i == 15);
      chk("fill_sfull", s_full, i == 15);
    end
    wdata = 8'hAA;
    tick();
    wr = 0;
    chk("ovf_level", f_level, 16);
    chk("ovf_set", f_ovf, 1);
    chk("ovf_set_std", s_ovf, 1);
    for (int i = 0; i < 16; i++) begin
      rd = 1;
      chk("drain_fdata", f_data, i);
      tick();
      chk("drain_svalid", s_valid, 1);
      chk("drain_sdata", s_data, i);
      chk("drain_level", f_level, 15 - i);
      chk("drain_aempty", f_ae, (15 - i) <= 2);
    end
    rd = 0;
    tick();
    chk("drain_empty", f_empty, 1);
    chk("drain_svalid_off", s_valid, 0);
    chk("drain_no_udf", f_udf, 0);
    clr = 1;
    tick();
    clr = 0;
    chk("ovf_clr", f_ovf, 0);
    wr = 1;
    wdata = 8'h5A;
    tick();
    wr = 0;
    chk("fw_not_empty", f_empty, 0);
    chk("fw_fvalid", f_valid, 1);
    rd = 1;
    chk("fw_same_cycle", f_data, 8'h5A);
    chk("std_no_valid_yet", s_valid, 0);
    tick();
    rd = 0;
    chk("fw_empty_after", f_empty, 1);
    chk("fw_fvalid_off", f_valid, 0);
    chk("std_valid", s_valid, 1);
    chk("std_data", s_data, 8'h5A);
    tick();
    chk("std_valid_pulse", s_valid, 0);
    chk("std_data_hold", s_data, 8'h5A);
    for (int i = 0; i < 8; i++) begin
      wr = 1;
      wdata = 8'(8'h10 + i);
      q.push_back(wdata);
      tick();
    end
    chk("mix_level0", f_level, 8);
    rd = 1;
    for (int i = 0; i < 20; i++) begin
      wdata = 8'($urandom_range(0, 255));
      head = q.pop_front();
      q.push_back(wdata);
      chk("mix_fdata", f_data, head);
      tick();
      chk("mix_sdata", s_data, head);
      chk("mix_level", f_level, 8);
    end
    wr = 0;
    for (int i = 0; i < 8; i++) begin
      head = q.pop_front();
      chk("mix_drain_fdata", f_data, head);
      tick();
      chk("mix_drain_sdata", s_data, head);
    end
    rd = 0;
    chk("mix_empty", f_empty, 1);
    chk("mix_no_udf", f_udf, 0);
    rd = 1;
    tick();
    rd = 0;
    chk("udf_set", f_udf, 1);
    chk("udf_set_std", s_udf, 1);
    chk("udf_no_ovf", f_ovf, 0);
    chk("udf_svalid", s_valid, 0);
    clr = 1;
    tick();
    chk("udf_clr", f_udf, 0);
    rd = 1;
    tick();
    chk("udf_set_wins", f_udf, 1);
    rd = 0;
    tick();
    clr = 0;
    chk("udf_clr2", s_udf, 0);
    for (int i = 0; i < 5; i++) begin
      wr = 1;
      wdata = 8'(8'h60 + i);
      tick();
    end
    chk("pre_rst_level", f_level, 5);
    wdata = 8'h77;
    nrst = 0;
    tick();
    nrst = 1;
    wr = 0;
    chk("mid_rst_level", f_level, 0);
    chk("mid_rst_empty", f_empty, 1);
    chk("mid_rst_svalid", s_valid, 0);
    chk("mid_rst_sdata", s_data, 0);
    rd = 1;
    tick();
    rd = 0;
    chk("post_rst_no_read", s_valid, 0);
    chk("post_rst_level", s_level, 0);
    wr = 1;
    wdata = 8'h33;
    tick();
    wr = 0;
    chk("post_rst_level1", f_level, 1);
    rd = 1;
    chk("post_rst_fdata", f_data, 8'h33);
    tick();
    rd = 0;
    chk("post_rst_sdata", s_data, 8'h33);
    chk("post_rst_empty", s_empty, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
